// File: rtl/seq_div32by16.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor. It produces one quotient bit per cycle, with signed or unsigned
// operation chosen per request.
//
// Handshake: an input transfer happens on an edge where in_valid && in_ready.
// An output transfer happens on an edge where out_valid && out_ready.
// in_ready is high only in IDLE and out_valid is high only in DONE, so only
// one division is in flight at a time.

module seq_div32by16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ovf,
    output logic                 div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;       // low dividend bits, refilled with quotient bits
    logic [WIDTH-1:0] div_q, div_d;       // |divisor|
    logic             neg_q, neg_d;       // quotient sign
    logic             rsign_q, rsign_d;   // remainder sign (dividend sign)
    logic             sgn_q, sgn_d;       // signed operation
    logic             big_q, big_d;       // upper dividend half >= divisor
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic               dvd_neg, div_neg;
    logic [2*WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0]   div_mag;
    logic [WIDTH+1:0]   shifted, trial;
    logic               fix_ovf;

    // Operand magnitudes, one restoring step, and the final overflow decision.
    always_comb begin
        dvd_neg = is_signed & dividend[2*WIDTH-1];
        div_neg = is_signed & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        div_mag = div_neg ? -divisor : divisor;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {2'b00, div_q};
        fix_ovf = big_q | (sgn_q & (neg_q ? (dvd_q > HALF) : dvd_q[WIDTH-1]));
    end

    // Next-state and next-output logic for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        div_d       = div_q;
        neg_d       = neg_q;
        rsign_d     = rsign_q;
        sgn_d       = sgn_q;
        big_d       = big_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sgn_d   = is_signed;
                    neg_d   = dvd_neg ^ div_neg;
                    rsign_d = dvd_neg;
                    rem_d   = {1'b0, dvd_mag[2*WIDTH-1:WIDTH]};
                    dvd_d   = dvd_mag[WIDTH-1:0];
                    div_d   = div_mag;
                    big_d   = (dvd_mag[2*WIDTH-1:WIDTH] >= div_mag);
                    cnt_d   = '0;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        // Divide by zero skips the iteration entirely.
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend[WIDTH-1:0];
                        ovf_d       = 1'b0;
                        dz_d        = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (trial[WIDTH+1]) begin
                    rem_d = shifted[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Apply signs; -0 remainder naturally comes out as 0.
                ovf_d       = fix_ovf;
                dz_d        = 1'b0;
                quotient_d  = fix_ovf ? {WIDTH{1'b0}} : (neg_q ? -dvd_q : dvd_q);
                remainder_d = fix_ovf ? {WIDTH{1'b0}}
                                      : (rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]);
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; results clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            div_q       <= '0;
            neg_q       <= 1'b0;
            rsign_q     <= 1'b0;
            sgn_q       <= 1'b0;
            big_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            div_q       <= div_d;
            neg_q       <= neg_d;
            rsign_q     <= rsign_d;
            sgn_q       <= sgn_d;
            big_q       <= big_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div32by16.sv
// Bench for seq_div32by16: directed vector table, reset-in-flight sequence,
// and randomized operations checked against an arithmetic reference model.

module tb_seq_div32by16;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          is_signed;
    logic [2*W-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          ovf;
    logic          div_zero;

    int n_vec = 0;
    int n_err = 0;

    logic [2*W+1:0] exp_q[$];   // {ovf, div_zero, quotient, remainder}

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [15:0] b;
        int          stall;
        logic [15:0] q;
        logic [15:0] r;
        bit          o;
        bit          z;
    } vec_t;

    vec_t tbl[8];

    seq_div32by16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [2*W+1:0] e);
        chk({tag, ".quotient"},  32'(quotient),  32'(e[2*W-1:W]));
        chk({tag, ".remainder"}, 32'(remainder), 32'(e[W-1:0]));
        chk({tag, ".ovf"},       32'(ovf),       32'(e[2*W+1]));
        chk({tag, ".div_zero"},  32'(div_zero),  32'(e[2*W]));
    endtask

    // Reference: plain integer division, truncating toward zero.
    task automatic model(input bit s, input logic [31:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output bit o, output bit z);
        longint sa, sb, lq, lr;
        if (b == 16'h0) begin
            q = 16'hFFFF; r = a[15:0]; o = 1'b0; z = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({48'h0, b});
            end
            lq = sa / sb;
            lr = sa % sb;
            o  = s ? (lq > 32767 || lq < -32768) : (lq > 65535);
            z  = 1'b0;
            q  = o ? 16'h0 : lq[15:0];
            r  = o ? 16'h0 : lr[15:0];
        end
    endtask

    // Driver: one complete operation with latency, backpressure and handshake checks.
    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [15:0] b, input int stall,
                          input logic [15:0] eq, input logic [15:0] er,
                          input bit eo, input bit ez);
        int n;
        logic [2*W+1:0] e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        out_ready = 1'b0;
        exp_q.push_back({eo, ez, eq, er});
        @(negedge clk);
        // Scramble operand ports after the accept edge; the operation must not notice.
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = 16'($urandom);
        is_signed = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(n), ez ? 32'd0 : 32'(LAT));
        e = exp_q.pop_front();
        chk_res(tag, e);
        chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < stall; k++) begin
            in_valid  = 1'b1;
            dividend  = $urandom;
            divisor   = 16'($urandom);
            @(negedge clk);
            chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
            chk_res({tag, ".stall"}, e);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(in_ready), 32'd1);
        chk_res({tag, ".post"}, e);
    endtask

    initial begin
        logic [15:0] mq, mr;
        bit          mo, mz;
        logic [31:0] ra;
        logic [15:0] rb;
        bit          rs;
        int          n;

        tbl[0] = '{1'b0, 32'h000186A0, 16'h012C, 0, 16'h014D, 16'h0064, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'hFFFFFFF9, 16'h0002, 1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h00010000, 16'h0001, 0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 32'h00008000, 16'h0001, 0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'hFFFF8000, 16'h0001, 0, 16'h8000, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'h12345678, 16'h0000, 2, 16'hFFFF, 16'h5678, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 32'h0000FFFF, 16'h0001, 5, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h00000064, 16'h0007, 0, 16'h000E, 16'h0002, 1'b0, 1'b0};

        // reset
        rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0; dividend = '0;
        divisor = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk_res("reset", '0);

        // directed table
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].stall,
                   tbl[i].q, tbl[i].r, tbl[i].o, tbl[i].z);
        end

        // reset during CALC cycle 7
        in_valid = 1'b1; is_signed = 1'b0; dividend = 32'h0000FFFF; divisor = 16'h0003;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk_res("midrst", '0);
        n = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("midrst.no_result", 32'(n), 32'd0);
        run_op("after_rst", 1'b0, 32'h00000064, 16'h0007, 0, 16'h000E, 16'h0002, 1'b0, 1'b0);

        // randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom_range(0, 1));
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = $urandom & 32'h00FF_FFFF;
                2: begin
                    ra = $urandom;
                    ra = {{8{ra[23]}}, ra[23:0]};
                end
                default: begin
                    ra = $urandom;
                    rb = 16'h0;
                end
            endcase
            model(rs, ra, rb, mq, mr, mo, mz);
            run_op($sformatf("rnd%0d", i), rs, ra, rb, $urandom_range(0, 3), mq, mr, mo, mz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
